// File: rtl/strobe_readback.sv
// rtl/strobe_readback.sv - burst readback of strobe vectors from a request-time snapshot
// Optional READBACK_PARITY_EN adds RD_PARITY (even parity of RD_DATA).
module strobe_readback #(
  parameter int ADDRESS_SIZE        = 10,
  parameter int DATA_SIZE           = 8,
  parameter int NB_SLAVES           = 4,
  parameter int SIZE_STROBE_DMSB    = 67,
  parameter int SIZE_STROBE_UMSB    = 67,
  parameter int SIZE_STROBE_BLE     = 68,
  parameter int HAS_DMSBOUT         = 0,
  parameter int SIZE_STROBE_DMSBOUT = 1,
  parameter int LEN_SIZE            = 4
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           REQ_VALID,
  output logic                           REQ_READY,
  input  logic [ADDRESS_SIZE-1:0]        REQ_ADDRESS,
  input  logic [LEN_SIZE-1:0]            REQ_LEN,
  input  logic [SIZE_STROBE_DMSB-1:0]    STROBE_DMSB,
  input  logic [SIZE_STROBE_UMSB-1:0]    STROBE_UMSB,
  input  logic [SIZE_STROBE_BLE-1:0]     STROBE_BLE,
  input  logic [SIZE_STROBE_DMSBOUT-1:0] STROBE_DMSBOUT,
  output logic [DATA_SIZE-1:0]           RD_DATA,
  output logic                           RD_VALID,
  input  logic                           RD_READY,
  output logic                           RD_LAST,
  output logic                           RD_ERROR,
`ifdef READBACK_PARITY_EN
  output logic                           RD_PARITY,
`endif
  output logic                           BUSY
);

  localparam int TSEL_W    = $clog2(NB_SLAVES + 2);
  localparam int IDXW      = ADDRESS_SIZE - TSEL_W;
  localparam int S         = SIZE_STROBE_BLE / NB_SLAVES;
  localparam int MAX_A     = (SIZE_STROBE_DMSB > SIZE_STROBE_UMSB) ? SIZE_STROBE_DMSB : SIZE_STROBE_UMSB;
  localparam int MAX_B     = (S > SIZE_STROBE_DMSBOUT) ? S : SIZE_STROBE_DMSBOUT;
  localparam int SNAP_W    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int WMAX      = (SNAP_W + DATA_SIZE - 1) / DATA_SIZE;
  localparam int SNAP_BITS = WMAX * DATA_SIZE;

  typedef logic [IDXW:0] wcnt_t;
  localparam wcnt_t W_BLE  = wcnt_t'((S + DATA_SIZE - 1) / DATA_SIZE);
  localparam wcnt_t W_DMSB = wcnt_t'((SIZE_STROBE_DMSB + DATA_SIZE - 1) / DATA_SIZE);
  localparam wcnt_t W_UMSB = wcnt_t'((SIZE_STROBE_UMSB + DATA_SIZE - 1) / DATA_SIZE);
  localparam wcnt_t W_DOUT = wcnt_t'((SIZE_STROBE_DMSBOUT + DATA_SIZE - 1) / DATA_SIZE);

  typedef enum logic [1:0] {IDLE, SNAP, SEND} state_t;

  state_t                 state_q;
  logic [TSEL_W-1:0]      tsel_q;
  logic [IDXW-1:0]        idx_q;
  logic [LEN_SIZE-1:0]    cnt_q;
  logic [SNAP_BITS-1:0]   snap_q, snap_d;
  wcnt_t                  words_q, words_d;
  logic                   bad_q, bad_d;
  logic                   req_ready_q, busy_q;
  logic                   rd_valid_q, rd_last_q, rd_error_q;
  logic [DATA_SIZE-1:0]   rd_data_q;

  logic [IDXW-1:0]        sel_idx;
  logic [LEN_SIZE-1:0]    sel_cnt;
  logic [DATA_SIZE-1:0]   word, beat_data;
  logic                   beat_err, beat_last;

  // Snapshot source, zero-extended to the widest target.
  always_comb begin
    snap_d  = '0;
    words_d = '0;
    bad_d   = 1'b0;
    if (tsel_q < TSEL_W'(NB_SLAVES)) begin
      for (int i = 0; i < NB_SLAVES; i++)
        if (tsel_q == TSEL_W'(i)) snap_d[S-1:0] = STROBE_BLE[i*S +: S];
      words_d = W_BLE;
    end else if (tsel_q == TSEL_W'(NB_SLAVES)) begin
      snap_d[SIZE_STROBE_DMSB-1:0] = STROBE_DMSB;
      words_d = W_DMSB;
    end else if (tsel_q == TSEL_W'(NB_SLAVES + 1)) begin
      snap_d[SIZE_STROBE_UMSB-1:0] = STROBE_UMSB;
      words_d = W_UMSB;
    end else if (HAS_DMSBOUT != 0 && tsel_q == TSEL_W'(NB_SLAVES + 2)) begin
      snap_d[SIZE_STROBE_DMSBOUT-1:0] = STROBE_DMSBOUT;
      words_d = W_DOUT;
    end else begin
      bad_d = 1'b1;
    end
  end

  // Beat to present next: the current one on first load, the following one after a handshake.
  always_comb begin
    sel_idx = rd_valid_q ? idx_q + 1'b1 : idx_q;
    sel_cnt = rd_valid_q ? cnt_q - 1'b1 : cnt_q;
    word    = '0;
    for (int k = 0; k < WMAX; k++)
      if (sel_idx == IDXW'(k)) word = snap_q[k*DATA_SIZE +: DATA_SIZE];
    beat_err  = bad_q || ({1'b0, sel_idx} >= words_q);
    beat_data = beat_err ? '0 : word;
    beat_last = bad_q || (sel_cnt == '0);
  end

`ifdef READBACK_PARITY_EN
  logic rd_parity_q;
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rd_parity_q <= 1'b0;
    end else if (state_q == SEND && (!rd_valid_q || RD_READY)) begin
      rd_parity_q <= (rd_valid_q && rd_last_q) ? 1'b0 : ^beat_data;
    end
  end
  assign RD_PARITY = rd_parity_q;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      tsel_q      <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      snap_q      <= '0;
      words_q     <= '0;
      bad_q       <= 1'b0;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_error_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (REQ_VALID && req_ready_q) begin
            tsel_q      <= REQ_ADDRESS[ADDRESS_SIZE-1 -: TSEL_W];
            idx_q       <= REQ_ADDRESS[IDXW-1:0];
            cnt_q       <= REQ_LEN;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= SNAP;
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        SNAP: begin
          snap_q  <= snap_d;
          words_q <= words_d;
          bad_q   <= bad_d;
          state_q <= SEND;
        end
        SEND: begin
          if (!rd_valid_q || RD_READY) begin
            if (rd_valid_q && rd_last_q) begin
              rd_valid_q  <= 1'b0;
              rd_last_q   <= 1'b0;
              rd_error_q  <= 1'b0;
              rd_data_q   <= '0;
              busy_q      <= 1'b0;
              req_ready_q <= 1'b1;
              state_q     <= IDLE;
            end else begin
              idx_q      <= sel_idx;
              cnt_q      <= sel_cnt;
              rd_valid_q <= 1'b1;
              rd_data_q  <= beat_data;
              rd_error_q <= beat_err;
              rd_last_q  <= beat_last;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign REQ_READY = req_ready_q;
  assign BUSY      = busy_q;
  assign RD_VALID  = rd_valid_q;
  assign RD_LAST   = rd_last_q;
  assign RD_ERROR  = rd_error_q;
  assign RD_DATA   = rd_data_q;

endmodule

// File: tb/tb_strobe_readback.sv
// tb/tb_strobe_readback.sv - table-driven scoreboard bench for strobe_readback
module tb_strobe_readback;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic [9:0]  REQ_ADDRESS;
  logic [3:0]  REQ_LEN;
  logic [66:0] STROBE_DMSB;
  logic [66:0] STROBE_UMSB;
  logic [67:0] STROBE_BLE;
  logic [0:0]  STROBE_DMSBOUT;
  logic [7:0]  RD_DATA;
  logic        RD_VALID;
  logic        RD_READY;
  logic        RD_LAST;
  logic        RD_ERROR;
  logic        BUSY;
`ifdef READBACK_PARITY_EN
  logic        RD_PARITY;
`endif

  strobe_readback dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_ADDRESS(REQ_ADDRESS), .REQ_LEN(REQ_LEN),
    .STROBE_DMSB(STROBE_DMSB), .STROBE_UMSB(STROBE_UMSB),
    .STROBE_BLE(STROBE_BLE), .STROBE_DMSBOUT(STROBE_DMSBOUT),
    .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .RD_READY(RD_READY),
    .RD_LAST(RD_LAST), .RD_ERROR(RD_ERROR),
`ifdef READBACK_PARITY_EN
    .RD_PARITY(RD_PARITY),
`endif
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  localparam logic [66:0] DMSB_V = 67'h5_A5A5_A5A5_A5A5_A5A5;
  localparam logic [66:0] UMSB_V = 67'h3_0123_4567_89AB_CDEF;
  localparam logic [67:0] BLE_V  = {17'h1_FFFF, 17'h1_2345, 17'h0_1234, 17'h1_BEEF};

  typedef struct {
    logic [7:0] d;
    logic       e;
    logic       l;
  } beat_t;

  typedef struct {
    logic [2:0] t;
    logic [6:0] idx;
    logic [3:0] len;
    bit         toggle;
    bit         chg;
    int         nbeats;
    logic [7:0] ldata;
    logic       lerr;
  } vec_t;

  beat_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_push(input logic [2:0] t, input logic [6:0] idx, input logic [3:0] len);
    logic [127:0] vec;
    int           w;
    bit           bad;
    int           nw;
    logic [6:0]   ix;
    beat_t        b;
    vec = '0;
    w   = 0;
    bad = 0;
    if (t < 3'd4) begin
      vec[16:0] = STROBE_BLE[int'(t)*17 +: 17];
      w = 17;
    end else if (t == 3'd4) begin
      vec[66:0] = STROBE_DMSB;
      w = 67;
    end else if (t == 3'd5) begin
      vec[66:0] = STROBE_UMSB;
      w = 67;
    end else begin
      bad = 1;
    end
    nw = (w + 7) / 8;
    for (int i = 0; i <= int'(len); i++) begin
      ix  = idx + 7'(i);
      b.e = bad || (int'(ix) >= nw);
      b.d = b.e ? 8'h00 : 8'(vec >> (int'(ix) * 8));
      b.l = bad || (i == int'(len));
      sb.push_back(b);
      if (bad) break;
    end
  endtask

  task automatic pop_compare();
    beat_t b;
    b = sb.pop_front();
    check("rd_data", 32'(RD_DATA), 32'(b.d));
    check("rd_error", 32'(RD_ERROR), 32'(b.e));
    check("rd_last", 32'(RD_LAST), 32'(b.l));
`ifdef READBACK_PARITY_EN
    check("rd_parity", 32'(RD_PARITY), 32'(b.e ? 1'b0 : ^b.d));
`endif
  endtask

  task automatic run_burst(input logic [2:0] t, input logic [6:0] idx, input logic [3:0] len,
                           input bit toggle, input bit chg,
                           output int nbeats, output logic [7:0] ldata, output logic lerr);
    int guard;
    bit phase;
    nbeats = 0;
    ldata  = 8'hxx;
    lerr   = 1'bx;
    phase  = 0;
    @(negedge CLK);
    REQ_VALID   = 1'b1;
    REQ_ADDRESS = {t, idx};
    REQ_LEN     = len;
    RD_READY    = 1'b0;
    guard = 0;
    while (!REQ_READY && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    check("req_ready_wait", 32'(REQ_READY), 32'd1);
    model_push(t, idx, len);
    @(negedge CLK);
    REQ_VALID = 1'b0;
    check("busy_snap", 32'(BUSY), 32'd1);
    check("req_ready_busy", 32'(REQ_READY), 32'd0);
    @(negedge CLK);
    check("lat_n1", 32'(RD_VALID), 32'd0);
    @(negedge CLK);
    check("lat_n2", 32'(RD_VALID), 32'd1);
    guard = 0;
    while (sb.size() > 0 && guard < 200) begin
      RD_READY = toggle ? phase : 1'b1;
      phase = ~phase;
      if (chg && nbeats == 1) STROBE_UMSB = 67'h7_FFFF_FFFF_FFFF_FFFF;
      if (RD_VALID) begin
        if (RD_READY) begin
          ldata = RD_DATA;
          lerr  = RD_ERROR;
          nbeats++;
          pop_compare();
        end else begin
          check("stall_data", 32'(RD_DATA), 32'(sb[0].d));
          check("stall_last", 32'(RD_LAST), 32'(sb[0].l));
        end
      end
      @(negedge CLK);
      guard++;
    end
    check("burst_timeout", 32'(sb.size()), 32'd0);
    sb.delete();
    RD_READY = 1'b1;
    check("no_extra_beat", 32'(RD_VALID), 32'd0);
    check("ready_after", 32'(REQ_READY), 32'd1);
  endtask

  vec_t tbl[9];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int         nb;
    logic [7:0] ld;
    logic       le;
    int         guard;

    tbl[0] = '{3'd4, 7'd0,   4'd8, 1'b0, 1'b0, 9, 8'h05, 1'b0};
    tbl[1] = '{3'd2, 7'd0,   4'd3, 1'b0, 1'b0, 4, 8'h00, 1'b1};
    tbl[2] = '{3'd6, 7'd0,   4'd5, 1'b0, 1'b0, 1, 8'h00, 1'b1};
    tbl[3] = '{3'd7, 7'd3,   4'd2, 1'b0, 1'b0, 1, 8'h00, 1'b1};
    tbl[4] = '{3'd5, 7'd7,   4'd1, 1'b0, 1'b0, 2, 8'h03, 1'b0};
    tbl[5] = '{3'd0, 7'd127, 4'd1, 1'b0, 1'b0, 2, 8'hEF, 1'b0};
    tbl[6] = '{3'd3, 7'd2,   4'd0, 1'b0, 1'b0, 1, 8'h01, 1'b0};
    tbl[7] = '{3'd1, 7'd1,   4'd0, 1'b0, 1'b0, 1, 8'h12, 1'b0};
    tbl[8] = '{3'd5, 7'd0,   4'd2, 1'b1, 1'b1, 3, 8'hAB, 1'b0};

    RESET          = 1'b1;
    REQ_VALID      = 1'b1;
    REQ_ADDRESS    = 10'h100;
    REQ_LEN        = 4'd0;
    RD_READY       = 1'b1;
    STROBE_DMSB    = DMSB_V;
    STROBE_UMSB    = UMSB_V;
    STROBE_BLE     = BLE_V;
    STROBE_DMSBOUT = 1'b1;

    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      check("rst_req_ready", 32'(REQ_READY), 32'd0);
      check("rst_rd_valid", 32'(RD_VALID), 32'd0);
      check("rst_busy", 32'(BUSY), 32'd0);
    end
    REQ_VALID = 1'b0;
    RESET     = 1'b0;
    @(negedge CLK);
    check("rst_release_ready", 32'(REQ_READY), 32'd1);

    for (int i = 0; i < 9; i++) begin
      run_burst(tbl[i].t, tbl[i].idx, tbl[i].len, tbl[i].toggle, tbl[i].chg, nb, ld, le);
      check("tbl_nbeats", 32'(nb), 32'(tbl[i].nbeats));
      check("tbl_last_data", 32'(ld), 32'(tbl[i].ldata));
      check("tbl_last_err", 32'(le), 32'(tbl[i].lerr));
    end
    STROBE_UMSB = UMSB_V;

    // Mid-burst reset on the second beat of a 4-beat UMSB burst.
    @(negedge CLK);
    REQ_VALID   = 1'b1;
    REQ_ADDRESS = {3'd5, 7'd0};
    REQ_LEN     = 4'd3;
    RD_READY    = 1'b1;
    @(negedge CLK);
    REQ_VALID = 1'b0;
    guard = 0;
    while (!RD_VALID && guard < 10) begin
      @(negedge CLK);
      guard++;
    end
    check("mr_first_valid", 32'(RD_VALID), 32'd1);
    check("mr_beat0", 32'(RD_DATA), 32'h00EF);
    @(negedge CLK);
    check("mr_beat1", 32'(RD_DATA), 32'h00CD);
    RESET = 1'b1;
    #1;
    check("mr_rd_valid", 32'(RD_VALID), 32'd0);
    check("mr_rd_data", 32'(RD_DATA), 32'd0);
    check("mr_rd_last", 32'(RD_LAST), 32'd0);
    check("mr_busy", 32'(BUSY), 32'd0);
    check("mr_req_ready", 32'(REQ_READY), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    run_burst(3'd5, 7'd2, 4'd1, 1'b0, 1'b0, nb, ld, le);
    check("mr_fresh_nbeats", 32'(nb), 32'd2);
    check("mr_fresh_last", 32'(ld), 32'h0089);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
